// File: rtl/proc_issue_ctrl.sv
// proc_issue_ctrl: issue controller in front of the proc datapath's 32-bit
// instruction input. Arbitrates two requesters round-robin, drops illegal
// instructions and inserts a bubble when a FETCH would read the location the
// immediately preceding instruction has not yet written back.
module proc_issue_ctrl #(
    parameter int          NREQ      = 2,
    parameter int          CNT_W     = 16,
    parameter logic [7:0]  BUBBLE_OP = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [NREQ-1:0]  i_req_valid,
    input  logic [31:0]      i_req_instr0,
    input  logic [31:0]      i_req_instr1,
    output logic [NREQ-1:0]  o_req_ready,
    output logic [31:0]      o_instr_out,
    output logic             o_err_pulse,
    output logic             o_err_src,
    output logic [CNT_W-1:0] o_issue_count,
    output logic [CNT_W-1:0] o_stall_count
);

    logic [2:0]       r_last_dest;
    logic             r_last_real;
    logic             r_rr_ptr;
    logic [31:0]      r_instr_out;
    logic             r_err_pulse;
    logic             r_err_src;
    logic [CNT_W-1:0] r_issue_count;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_go;
    logic [1:0]       w_haz;
    logic [1:0]       w_ok;
    logic             w_any;
    logic             w_gidx;
    logic             w_stall;
    logic [31:0]      w_sel_instr;
    logic             w_sel_legal;
    logic [31:0]      w_bubble;

    // Legal: known opcode, dest within storage, FETCH address within storage.
    function automatic logic f_legal(input logic [31:0] ins);
        return (ins[31:24] <= 8'd2) && (ins[23:16] <= 8'd7) &&
               ((ins[31:24] != 8'd2) || (ins[7:0] <= 8'd7));
    endfunction

    // A legal FETCH reading the location the last real instruction writes.
    function automatic logic f_hazard(input logic [31:0] ins, input logic last_real,
                                      input logic [2:0] last_dest);
        return f_legal(ins) && (ins[31:24] == 8'd2) && last_real &&
               (ins[2:0] == last_dest);
    endfunction

    // Bubble rewrites the last written location, so it has no side effect.
    assign w_bubble = {BUBBLE_OP, 5'b00000, r_last_dest, 16'h0000};
    assign w_go     = i_en & ~rst;
    assign w_haz[0] = f_hazard(i_req_instr0, r_last_real, r_last_dest);
    assign w_haz[1] = f_hazard(i_req_instr1, r_last_real, r_last_dest);
    assign w_ok     = i_req_valid[1:0] & ~w_haz;

    // Priority requester first if it can go, otherwise the other; a valid
    // requester left ungranted can only have been blocked by a hazard.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = 1'b0;
        if (w_go) begin
            if (w_ok[r_rr_ptr]) begin
                w_any  = 1'b1;
                w_gidx = r_rr_ptr;
            end else if (w_ok[~r_rr_ptr]) begin
                w_any  = 1'b1;
                w_gidx = ~r_rr_ptr;
            end
        end
    end

    assign w_stall     = w_go & ~w_any & (|i_req_valid);
    assign o_req_ready = w_any ? (NREQ'(1) << w_gidx) : '0;
    assign w_sel_instr = w_gidx ? i_req_instr1 : i_req_instr0;
    assign w_sel_legal = f_legal(w_sel_instr);

    // Issue register, hazard tracking state, error flag and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_out   <= {BUBBLE_OP, 24'h000000};
            r_last_dest   <= 3'd0;
            r_last_real   <= 1'b0;
            r_rr_ptr      <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_src     <= 1'b0;
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_any) begin
                r_rr_ptr <= ~w_gidx;
                if (w_sel_legal) begin
                    r_instr_out <= w_sel_instr;
                    r_last_dest <= w_sel_instr[18:16];
                    r_last_real <= 1'b1;
                    if (r_issue_count != '1)
                        r_issue_count <= r_issue_count + CNT_W'(1);
                end else begin
                    r_instr_out <= w_bubble;
                    r_last_real <= 1'b0;
                    r_err_pulse <= 1'b1;
                    r_err_src   <= w_gidx;
                end
            end else begin
                r_instr_out <= w_bubble;
                r_last_real <= 1'b0;
                if (w_stall && (r_stall_count != '1))
                    r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign o_instr_out   = r_instr_out;
    assign o_err_pulse   = r_err_pulse;
    assign o_err_src     = r_err_src;
    assign o_issue_count = r_issue_count;
    assign o_stall_count = r_stall_count;

endmodule

// File: doc/proc_issue_ctrl.md
# proc_issue_ctrl

Issue controller that sits in front of the 32-bit instruction input of the `proc` datapath. It arbitrates between two instruction requesters with round-robin priority and filters out illegal instructions. It inserts a safe bubble whenever a fetch would read a storage location that the immediately preceding instruction has not yet written back. It drives `proc.instr` from a register every cycle and keeps issue and stall statistics.

## Interface
- `NREQ`, 2: number of requesters. Fixed at 2.
- `CNT_W`, 16: width of the statistics counters.
- `BUBBLE_OP`, 8'hFF: opcode used for bubbles.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: issue enable. When low, no grants are made and bubbles are issued.
- `req_valid`  in  2: per-requester instruction valid.
- `req_instr0`  in  32: requester 0 instruction, format {op[31:24], dest[23:16], b[15:8], a[7:0]}.
- `req_instr1`  in  32: requester 1 instruction.
- `req_ready`  out  2: per-requester accept. Combinational, one-hot or zero.
- `instr_out`  out  32: registered instruction, connected to `proc.instr`.
- `err_pulse`  out  1: registered, one cycle high per dropped illegal instruction.
- `err_src`  out  1: requester index of the last dropped instruction.
- `issue_count`  out  CNT_W: number of legal instructions issued.
- `stall_count`  out  CNT_W: number of hazard-stall cycles.

## Operation
- Opcodes: 0 = AND, 1 = ADD, 2 = FETCH (reads storage[a]).
  - Every instruction the datapath decodes writes storage[dest], two edges after it is captured. This includes unknown opcodes, which write stale data.
- Legal instruction:
  - op ∈ {0,1,2} and dest ≤ 7.
  - If op = 2, additionally a ≤ 7.
  - Anything else is illegal.
- Bubble is {BUBBLE_OP, last_dest, 16'h0000}.
  - It rewrites the previously written location with its unchanged value, so it has no side effect.
- State registers:
  - `last_dest[2:0]`
  - `last_real`: the previous `instr_out` was a legal, non-bubble instruction.
  - `rr_ptr`: the requester that has priority.
- Hazard for a candidate: op = 2, last_real = 1, and a[2:0] == last_dest.
- Grant selection each cycle, with `en` = 1:
  - Primary requester is `rr_ptr` if it is valid, otherwise the other requester.
  - If the primary is hazardous and the other requester is valid and non-hazardous, grant the other.
  - If the only candidates are hazardous, grant none and record a stall.
  - Illegal instructions are never hazardous. They are granted normally and dropped.
- On the edge where a grant is made (valid & ready):
  - Legal instruction: `instr_out` ← instruction, `last_dest` ← dest, `last_real` ← 1, `issue_count`++.
  - Illegal instruction: `instr_out` ← bubble, `last_real` ← 0, `err_pulse` ← 1, `err_src` ← index.
  - `rr_ptr` ← granted index ^ 1.
- On an edge with no grant:
  - `instr_out` ← bubble, `last_real` ← 0, `rr_ptr` unchanged.
  - `stall_count`++ only when a hazard blocked a valid requester.
- Counters saturate at all-ones.
- `en` = 0: `req_ready` = 0 and bubbles are issued. Not a stall.

## Timing
- Reset values:
  - `instr_out` = {8'hFF, 8'h00, 16'h0000}
  - `req_ready` = 0 (combinational, forced by reset state only through `en`/valid)
  - `err_pulse` = 0, `err_src` = 0
  - `issue_count` = 0, `stall_count` = 0
  - `last_dest` = 0, `last_real` = 0, `rr_ptr` = 0
- `req_ready` depends combinationally on `req_valid`, the instruction fields, `en` and state. Requesters must not make `req_valid` depend on `req_ready`.
- Latency: an instruction accepted at edge N appears on `instr_out` after edge N.
  - The datapath decodes it at N+1, executes it at N+2 and writes storage at N+3.
- Hazard spacing: a FETCH reading the dest of the instruction issued one cycle earlier gets exactly one bubble between them. A FETCH two or more issues later proceeds without a stall.
- Back-to-back issue: at most one instruction per cycle, with no dead cycles when there is no hazard.
- Both requesters valid and legal: grants alternate strictly 0,1,0,1.
- Reset mid-operation: all state clears immediately. A request held across reset is granted fresh on the first enabled edge after deassertion.
- `err_pulse` is high for exactly the cycle after a drop edge.

## Test plan
- **Reset:** assert `rst` mid-stream → `instr_out` = 32'hFF000000, counters 0 and `req_ready` = 0 while `rst` is high, asynchronously.
- **Round-robin:** both requesters valid with ADD {01,03,05,02} and AND {00,04,0F,0A} → grants alternate 0,1,0,1, `instr_out` alternates accordingly, and `issue_count` increments every cycle.
- **Hazard stall:**
  - Stimulus: requester 0 issues ADD dest=5 (32'h01050302); next cycle requester 0 presents FETCH a=5 (32'h02010005) and requester 1 is idle.
  - Required response: one bubble 32'hFF050000 is issued, then the FETCH; `stall_count` = 1.
- **Hazard bypass:** same as the previous scenario, but requester 1 presents legal ADD dest=2 in the same cycle → requester 1 is granted with no bubble; the FETCH issues the following cycle and `stall_count` stays 0.
- **Illegal instruction:** requester 1 sends op = 8'h07, or dest = 9 → `req_ready[1]` = 1, `instr_out` = bubble, `err_pulse` high for 1 cycle, `err_src` = 1 and `issue_count` unchanged.
- **Enable low and saturation:** `en` = 0 for 10 cycles with both valid → 10 bubbles and no change to the counters. Preload `issue_count` to 16'hFFFF via a long run → it holds 16'hFFFF.
